// File: rtl/axi_slave_mem.sv
// AXI3 slave memory: one outstanding write (AW/W/B) and read (AR/R).
// Define AXI_SLV_OOR_SLVERR_EN to flag beats >= MEM_DEPTH*4 as SLVERR.
// Ports: ACLK, ARESETn (sync, active low); AW*/W*/B* write channels;
// AR*/R* read channels. All outputs are registered.
module axi_slave_mem #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ID_W-1:0]   WID,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  // WID is accepted but never compared against AWID.
  logic unused_wid;
  assign unused_wid = ^WID;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a,
    input logic [3:0]        len,
    input logic [2:0]        size,
    input logic [1:0]        burst
  );
    logic [1:0]        sz;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] sum;
    logic [ADDR_W-1:0] mask;
    logic              wrap_ok;
    sz      = (size > 3'd2) ? 2'd2 : size[1:0];
    inc     = ADDR_W'(1) << sz;
    sum     = a + inc;
    mask    = ((ADDR_W'(len) + ADDR_W'(1)) << sz) - ADDR_W'(1);
    wrap_ok = (len == 4'd1) || (len == 4'd3) ||
              (len == 4'd7) || (len == 4'd15);
    unique case (1'b1)
      burst == 2'b00:
        return a;
      burst == 2'b10 && wrap_ok:
        return (a & ~mask) | (sum & mask);
      default:
        return sum;
    endcase
  endfunction

  // ---------------- write path ----------------
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [3:0]        wlen_q, wlen_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              werr_q, werr_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              mem_we;
  logic              w_oor;
  logic [IDX_W-1:0]  w_idx;

  assign w_idx = waddr_q[IDX_W+1:2];

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (AWVALID && awready_q) begin
          bid_d     = AWID;
          waddr_d   = AWADDR;
          wlen_d    = AWLEN;
          wsize_d   = AWSIZE;
          wburst_d  = AWBURST;
          wcnt_d    = AWLEN;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID && wready_q) begin
          mem_we = !w_oor;
          // Length comes from AWLEN; WLAST only grades the master.
          if ((WLAST != (wcnt_q == 4'd0)) || w_oor)
            werr_d = 1'b1;
          waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
          wcnt_d  = wcnt_q - 4'd1;
          if (wcnt_q == 4'd0)
            w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY && bvalid_q)
          w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = (bvalid_d && werr_d) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // RAM survives reset; a beat on a reset edge is dropped.
  always_ff @(posedge ACLK) begin
    if (ARESETn && mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b])
          mem_q[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;

  // ---------------- read path ----------------
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [3:0]        rlen_q, rlen_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d;
  logic [3:0]        rcnt_q, rcnt_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              ar_oor;
  logic              rn_oor;
  logic [IDX_W-1:0]  ar_idx;
  logic [IDX_W-1:0]  rn_idx;

  assign ar_idx = ARADDR[IDX_W+1:2];
  assign rn_idx = raddr_q[IDX_W+1:2];

`ifdef AXI_SLV_OOR_SLVERR_EN
  assign w_oor  = |waddr_q[ADDR_W-1:IDX_W+2];
  assign ar_oor = |ARADDR[ADDR_W-1:IDX_W+2];
  assign rn_oor = |raddr_q[ADDR_W-1:IDX_W+2];
`else
  assign w_oor  = 1'b0;
  assign ar_oor = 1'b0;
  assign rn_oor = 1'b0;
`endif

  // raddr_q always holds the address of the beat after the one on RDATA.
  // mem_q is read before this edge's write lands: old data on collision.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ARVALID && arready_q) begin
          rid_d     = ARID;
          rlen_d    = ARLEN;
          rsize_d   = ARSIZE;
          rburst_d  = ARBURST;
          rcnt_d    = ARLEN;
          raddr_d   = next_addr(ARADDR, ARLEN, ARSIZE, ARBURST);
          rdata_d   = ar_oor ? '0 : mem_q[ar_idx];
          rresp_d   = ar_oor ? 2'b10 : 2'b00;
          rlast_d   = (ARLEN == 4'd0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY && rvalid_q) begin
          if (rcnt_q == 4'd0) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            rdata_d = rn_oor ? '0 : mem_q[rn_idx];
            rresp_d = rn_oor ? 2'b10 : 2'b00;
            raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
            rcnt_d  = rcnt_q - 4'd1;
            rlast_d = (rcnt_q == 4'd1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: directed plus random bursts.
// Expected B/R responses come from a byte-address reference model.
module tb_axi_slave_mem;
  localparam int MEM_DEPTH = 1024;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [3:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [3:0]  WID = '0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [3:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b1;

  axi_slave_mem #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  int checks = 0;
  int failures = 0;
  int r_hs = 0;
  bit rready_rand = 0;
  bit bready_rand = 0;
  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  logic [31:0] ref_mem [MEM_DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------- reference model (byte addresses, plain arithmetic) ----------
  function automatic logic [31:0] beat_addr(input logic [31:0] start,
      input int len, input int size, input int burst, input int i);
    logic [31:0] nb, wb, base;
    nb = 32'(1) << ((size > 2) ? 2 : size);
    if (burst == 0) return start;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      wb   = 32'(len + 1) * nb;
      base = start - (start % wb);
      return base + ((start - base + 32'(i) * nb) % wb);
    end
    return start + 32'(i) * nb;
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
    bit en;
`ifdef AXI_SLV_OOR_SLVERR_EN
    en = 1;
`else
    en = 0;
`endif
    return en && (a >= 32'(MEM_DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(MEM_DEPTH));
  endfunction

  // ---------- handshake helpers ----------
  task automatic wait_rdy(input int which, input string name);
    int  n;
    logic r;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
      case (which)
        0: r = AWREADY;
        1: r = WREADY;
        default: r = ARREADY;
      endcase
    end while (!r && n < 100);
    if (!r) tmo(name);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
      input logic [3:0] len, input logic [2:0] size,
      input logic [1:0] burst, input int wl_mode);
    bit err;
    logic [31:0] a;
    logic wl;
    int n;
    b_exp_t e;
    err = (wl_mode != 0);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, int'(len), int'(size), int'(burst), i);
      if (is_oor(a)) err = 1;
      else
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) ref_mem[widx(a)][8*b +: 8] = wd[i][8*b +: 8];
    end
    e.id = id;
    e.resp = err ? 2'b10 : 2'b00;
    exp_b.push_back(e);
    AWID = id; AWADDR = addr; AWLEN = len;
    AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    wait_rdy(0, "aw_handshake");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wl = (i == int'(len));
      if (wl_mode == 1 && i == int'(len)) wl = 1'b0;
      if (wl_mode == 2 && i == 0) wl = ~wl;
      WID = id; WDATA = wd[i]; WSTRB = ws[i];
      WLAST = wl; WVALID = 1'b1;
      wait_rdy(1, "w_handshake");
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    WLAST = 1'b0;
    n = 0;
    while (exp_b.size() != 0 && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (exp_b.size() != 0) begin
      tmo("b_response");
      exp_b.delete();
    end
    @(posedge ACLK); #1;
  endtask

  task automatic issue_read(input logic [3:0] id, input logic [31:0] addr,
      input logic [3:0] len, input logic [2:0] size,
      input logic [1:0] burst);
    logic [31:0] a;
    r_exp_t r;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, int'(len), int'(size), int'(burst), i);
      r.id = id;
      r.last = (i == int'(len));
      if (is_oor(a)) begin
        r.data = '0;
        r.resp = 2'b10;
      end else begin
        r.data = ref_mem[widx(a)];
        r.resp = 2'b00;
      end
      exp_r.push_back(r);
    end
    ARID = id; ARADDR = addr; ARLEN = len;
    ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    wait_rdy(2, "ar_handshake");
    chk("rvalid_before_ar", 32'(RVALID), 32'd0);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(negedge ACLK);
    chk("rvalid_latency", 32'(RVALID), 32'd1);
  endtask

  task automatic wait_read();
    int n;
    n = 0;
    while (exp_r.size() != 0 && n < 400) begin
      @(negedge ACLK);
      n++;
    end
    if (exp_r.size() != 0) begin
      tmo("r_burst");
      exp_r.delete();
    end
    @(posedge ACLK); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_awready"}, 32'(AWREADY), 32'd0);
    chk({tag, "_wready"}, 32'(WREADY), 32'd0);
    chk({tag, "_bvalid"}, 32'(BVALID), 32'd0);
    chk({tag, "_arready"}, 32'(ARREADY), 32'd0);
    chk({tag, "_rvalid"}, 32'(RVALID), 32'd0);
    chk({tag, "_rlast"}, 32'(RLAST), 32'd0);
    chk({tag, "_bid"}, 32'(BID), 32'd0);
    chk({tag, "_bresp"}, 32'(BRESP), 32'd0);
    chk({tag, "_rid"}, 32'(RID), 32'd0);
    chk({tag, "_rdata"}, RDATA, 32'd0);
    chk({tag, "_rresp"}, 32'(RRESP), 32'd0);
  endtask

  // ---------- random ready drivers ----------
  initial forever begin
    @(posedge ACLK); #1;
    if (rready_rand) RREADY = ($urandom_range(0, 3) != 0);
    if (bready_rand) BREADY = ($urandom_range(0, 2) != 0);
  end

  // ---------- monitor / scoreboard ----------
  initial begin : monitor
    bit stall_prev;
    logic [31:0] s_data;
    logic [3:0]  s_id;
    logic [1:0]  s_resp;
    logic        s_last;
    b_exp_t be;
    r_exp_t re;
    stall_prev = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          chk("r_stall_valid", 32'(RVALID), 32'd1);
          chk("r_stall_data", RDATA, s_data);
          chk("r_stall_id", 32'(RID), 32'(s_id));
          chk("r_stall_resp", 32'(RRESP), 32'(s_resp));
          chk("r_stall_last", 32'(RLAST), 32'(s_last));
        end
        if (BVALID && BREADY) begin
          if (exp_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected: got BID=%0h required no response",
                     BID);
          end else begin
            be = exp_b.pop_front();
            chk("bid", 32'(BID), 32'(be.id));
            chk("bresp", 32'(BRESP), 32'(be.resp));
          end
        end
        if (RVALID && RREADY) begin
          r_hs++;
          if (exp_r.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL r_unexpected: got RDATA=%0h required no beat",
                     RDATA);
          end else begin
            re = exp_r.pop_front();
            chk("rid", 32'(RID), 32'(re.id));
            chk("rdata", RDATA, re.data);
            chk("rresp", 32'(RRESP), 32'(re.resp));
            chk("rlast", 32'(RLAST), 32'(re.last));
          end
        end
        stall_prev = RVALID && !RREADY;
        s_data = RDATA;
        s_id = RID;
        s_resp = RRESP;
        s_last = RLAST;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------- stimulus ----------
  initial begin : stim
    int hs0;
    logic [31:0] a;
    logic [3:0]  len;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_vals("rst");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("awready_after_rst", 32'(AWREADY), 32'd1);
    chk("arready_after_rst", 32'(ARREADY), 32'd1);
    @(posedge ACLK); #1;

    // Preload the whole RAM so every later read is defined.
    for (int k = 0; k < MEM_DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'hF;
      end
      do_write(4'(k), 32'(k * 64), 4'd15, 3'd2, 2'b01, 0);
    end

    // Reset in the middle of a 4-beat write: no B, then clean restart.
    AWID = 4'h3; AWADDR = 32'h40; AWLEN = 4'd3;
    AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    wait_rdy(0, "aw_abort");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WDATA = $urandom; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      ref_mem[16 + i] = WDATA;
      wait_rdy(1, "w_abort");
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check_reset_vals("midrst");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("awready_after_midrst", 32'(AWREADY), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      chk("bvalid_after_abort", 32'(BVALID), 32'd0);
    end
    @(posedge ACLK); #1;
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'hF;
    end
    do_write(4'h3, 32'h40, 4'd3, 3'd2, 2'b01, 0);

    // INCR write then INCR and WRAP reads.
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'hA0 + 32'(i);
      ws[i] = 4'hF;
    end
    do_write(4'h5, 32'h100, 4'd3, 3'd2, 2'b01, 0);
    issue_read(4'h6, 32'h100, 4'd3, 3'd2, 2'b01);
    wait_read();
    issue_read(4'h7, 32'h108, 4'd3, 3'd2, 2'b10);
    wait_read();

    // Byte strobes: 0xFFFFFFFF then 0x12345678 with lanes 0 and 2.
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_write(4'h1, 32'h200, 4'd0, 3'd2, 2'b01, 0);
    wd[0] = 32'h1234_5678; ws[0] = 4'h5;
    do_write(4'h1, 32'h200, 4'd0, 3'd2, 2'b01, 0);
    chk("strobe_model", ref_mem[128], 32'hFF34_FF78);
    issue_read(4'h2, 32'h200, 4'd0, 3'd2, 2'b01);
    wait_read();

    // Missing WLAST on final beat: SLVERR, data still written.
    wd[0] = 32'hC0DE_0001; wd[1] = 32'hC0DE_0002;
    ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(4'h2, 32'h300, 4'd1, 3'd2, 2'b01, 1);

    // RREADY pattern 1,0,0,1 on a 2-beat read.
    RREADY = 1'b1;
    hs0 = r_hs;
    issue_read(4'h9, 32'h300, 4'd1, 3'd2, 2'b01);
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    @(posedge ACLK); #1;
    RREADY = 1'b1;
    wait_read();
    chk("r_handshakes", 32'(r_hs - hs0), 32'd2);

    // Top-of-range accesses: alias by default, SLVERR with OOR checking.
    issue_read(4'hA, 32'h1000, 4'd0, 3'd2, 2'b01);
    wait_read();
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'hF;
    end
    do_write(4'hB, 32'hFF8, 4'd3, 3'd2, 2'b01, 0);
    issue_read(4'hC, 32'hFF8, 4'd3, 3'd2, 2'b01);
    wait_read();

    // Randomized bursts with random back-pressure.
    rready_rand = 1;
    bready_rand = 1;
    for (int it = 0; it < 60; it++) begin
      a = 32'($urandom_range(0, MEM_DEPTH - 1)) * 32'd4;
      if ($urandom_range(0, 7) == 0)
        a = a + 32'h1000 * 32'($urandom_range(1, 2));
      len = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'($urandom);
      end
      do_write(4'($urandom), a, len, 3'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)),
               ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0);
      issue_read(4'($urandom), a, 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      wait_read();
    end
    rready_rand = 0;
    bready_rand = 0;
    RREADY = 1'b1;
    BREADY = 1'b1;
    repeat (4) @(posedge ACLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- AXI3 slave memory model: the design-under-test endpoint that consumes the write/read bursts produced by the bench master driving the AXI interface.
- Independent write path (AW/W/B) and read path (AR/R), each with one outstanding transaction.
- Word-organised internal RAM, byte-strobed writes, FIXED/INCR/WRAP bursts of 1–16 beats.
- Used as the reference slave for AXI driver/monitor/scoreboard bring-up.

Parameters:
- ID_W, 4, width of AWID/WID/BID/ARID/RID
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32; STRB width DATA_W/8)
- MEM_DEPTH, 1024, RAM depth in 32-bit words (power of 2)

Ports:
- ACLK  in  1  clock, all logic on posedge
- ARESETn  in  1  synchronous active-low reset
- AWID  in  ID_W  write id
- AWADDR  in  ADDR_W  write start byte address
- AWLEN  in  4  beats-1
- AWSIZE  in  3  bytes per beat = 1<<AWSIZE
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
- AWVALID  in  1 / AWREADY  out  1  AW handshake
- WID  in  ID_W  write data id (not checked)
- WDATA  in  DATA_W  write data
- WSTRB  in  DATA_W/8  byte enables
- WLAST  in  1  last beat marker
- WVALID  in  1 / WREADY  out  1  W handshake
- BID  out  ID_W  = captured AWID
- BRESP  out  2  00 OKAY, 10 SLVERR
- BVALID  out  1 / BREADY  in  1  B handshake
- ARID, ARADDR, ARLEN, ARSIZE, ARBURST  in  ID_W/ADDR_W/4/3/2  read command, same encoding as AW
- ARVALID  in  1 / ARREADY  out  1  AR handshake
- RID  out  ID_W  = captured ARID
- RDATA  out  DATA_W  read data
- RRESP  out  2  00 OKAY, 10 SLVERR
- RLAST  out  1  final beat
- RVALID  out  1 / RREADY  in  1  R handshake

Behaviour:
- Reset: ARESETn sampled low at posedge -> both FSMs to IDLE; AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, BRESP, RID, RDATA, RRESP = 0. RAM contents not cleared. AWREADY/ARREADY = 1 on the first cycle after reset release. A burst in flight at reset is aborted with no response.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, capture id/addr/len/size/burst, beat counter=AWLEN, clear error flag, go W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes RAM[addr[log2(MEM_DEPTH)+1:2]] byte lanes per WSTRB, then advances addr and decrements the counter. WLAST=1 on a non-final beat, or WLAST=0 on the final beat, sets the error flag. The burst always terminates on the counter, never on WLAST. After the final beat go W_RESP.
  - W_RESP: BVALID=1, BID=captured id, BRESP=SLVERR if error flag else OKAY. Hold until BREADY, then W_IDLE.
  - Minimum AW-to-AW spacing: len+3 cycles.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. On handshake, capture the command and load RDATA from RAM at the start address. RVALID=1 the next cycle (1-cycle latency).
  - R_DATA: RID, RDATA, RRESP, RLAST stay stable while RVALID & !RREADY. On RVALID&RREADY with beats remaining, load the next beat; RVALID stays 1 (one beat per cycle sustained). RLAST=1 only on the final beat. After the final handshake: RVALID=0, go R_IDLE.
- Address advance:
  - SIZE>2 is treated as 2.
  - FIXED: addr unchanged.
  - INCR (and reserved 11): addr += 1<<size.
  - WRAP: mask=((len+1)<<size)-1; addr = (addr & ~mask) | ((addr + (1<<size)) & mask). WRAP with len not in {1,3,7,15} is treated as INCR.
- Address mapping: RAM index ignores bits above log2(MEM_DEPTH)+1, so addresses alias modulo MEM_DEPTH*4 unless the optional feature is on.
- Collision: a read beat loaded on the same edge as a write to that word returns the pre-write data. Writes committed at earlier edges are visible.
- Write and read paths run fully concurrently; no ordering between them.

Optional Feature:
- AXI_SLV_OOR_SLVERR_EN defined: any beat whose address >= MEM_DEPTH*4 is out of range.
  - Write: the beat is not written and the error flag is set (BRESP=SLVERR).
  - Read: that beat returns RDATA=0, RRESP=SLVERR; other beats return OKAY.
- Undefined: addresses alias modulo MEM_DEPTH*4; OOR never causes SLVERR (WLAST mismatch still does).

Test Plan:
- Reset mid-burst: AWLEN=3, ARESETn low after beat 1 -> BVALID never asserts; AWREADY=1 the cycle after release; next write completes with OKAY.
- INCR write AWADDR=0x100, AWLEN=3, SIZE=2, data 0xA0..0xA3, WSTRB=0xF; then read ARADDR=0x100, ARLEN=3 -> BRESP=00, BID=AWID; RDATA 0xA0,0xA1,0xA2,0xA3; RLAST only on beat 4; first RVALID 1 cycle after AR handshake.
- WRAP read ARADDR=0x108, ARLEN=3, SIZE=2 after the INCR write -> RDATA order 0xA2,0xA3,0xA0,0xA1.
- Strobe: write 0xFFFFFFFF to 0x200 (WSTRB=0xF), then 0x12345678 with WSTRB=0x5 -> read returns 0xFF34FF78.
- WLAST missing on the final beat of AWLEN=1 -> BRESP=10; RAM still updated for both beats.
- RREADY toggled 1,0,0,1 during ARLEN=1 read -> RDATA/RLAST held stable while stalled; exactly 2 handshakes; AXI_SLV_OOR_SLVERR_EN build: read at 0x1000 with MEM_DEPTH=1024 -> RRESP=10, RDATA=0.
